uart_rx_pkt_ctrl: RTL
=====================

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: first byte of every frame.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 1740: inter-byte timeout in clocks, legal range 2..65535.
REQ-003 SHALL have port i_Clock  input  1: sole clock; all logic on rising edge.
REQ-004 SHALL have port i_Rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port i_Rx_DV  input  1: one-cycle strobe marking a received byte.
REQ-006 SHALL have port i_Rx_Byte  input  8: received byte, valid when i_Rx_DV=1.
REQ-007 SHALL have port o_Pkt_Valid  output  1: a decoded write request is held.
REQ-008 SHALL have port i_Pkt_Ready  input  1: consumer accepts the request.
REQ-009 SHALL have port o_Pkt_Addr  output  8: register address of the held request.
REQ-010 SHALL have port o_Pkt_Data  output  8: write data of the held request.
REQ-011 SHALL have port o_Timeout  output  1: one-cycle pulse when a partial frame is abandoned.
REQ-012 SHALL have port o_Err_Cnt  output  8: saturating count of checksum failures.
REQ-013 SHALL have port o_Drop_Cnt  output  8: saturating count of good frames dropped because the output was full.

Function
REQ-014 SHALL decode frames SYNC_BYTE, ADDR, DATA[, CSUM], one byte per i_Rx_DV strobe.
REQ-015 SHALL use states S_IDLE, S_ADDR, S_DATA, S_CSUM; bytes other than SYNC_BYTE in S_IDLE are ignored.
REQ-016 SHALL advance S_IDLE->S_ADDR on SYNC_BYTE, S_ADDR->S_DATA on any byte, S_DATA->S_CSUM (or ->S_IDLE when the frame completes), S_CSUM->S_IDLE.
REQ-017 SHALL treat a SYNC_BYTE value received after S_IDLE as an ordinary payload byte; there is no mid-frame resync.
REQ-018 SHALL compute the expected checksum as (SYNC_BYTE + ADDR + DATA) mod 256, using an 8-bit wrapping sum.
REQ-019 SHALL, on frame completion with a good checksum and o_Pkt_Valid=0, load o_Pkt_Addr and o_Pkt_Data and assert o_Pkt_Valid on the next cycle.
REQ-020 SHALL hold o_Pkt_Valid, o_Pkt_Addr and o_Pkt_Data stable until a cycle with o_Pkt_Valid=1 and i_Pkt_Ready=1, then deassert o_Pkt_Valid.
REQ-021 SHALL treat a completing frame in the same cycle as an accepting handshake as loading into the freed slot, with o_Pkt_Valid staying 1.
REQ-022 SHALL drop a good frame that completes while the slot is occupied and not being accepted, and increment o_Drop_Cnt, saturating at 255.
REQ-023 SHALL discard a bad-checksum frame and increment o_Err_Cnt, saturating at 255.
REQ-024 SHALL run a 16-bit idle counter in every state except S_IDLE; it clears on each i_Rx_DV.
REQ-025 SHALL, when the counter reaches TIMEOUT_CLKS-1 without i_Rx_DV, go to S_IDLE and pulse o_Timeout for 1 cycle.
REQ-026 SHALL process a byte normally when i_Rx_DV coincides with the timeout cycle; in that case there is no timeout.

Reset
REQ-027 SHALL, while i_Rst_n=0, force state to S_IDLE and drive o_Pkt_Valid=0, o_Pkt_Addr=0, o_Pkt_Data=0, o_Timeout=0, o_Err_Cnt=0, o_Drop_Cnt=0, with the idle counter at 0.
REQ-028 SHALL, on reset assertion mid-frame or with a held request, discard the partial frame and the held request; no counter increments.

Configuration
REQ-029 SHALL compile the checksum byte and S_CSUM only when UART_PKT_CHECKSUM_EN is defined; with it, frames are 4 bytes and checked.
REQ-030 SHALL, without UART_PKT_CHECKSUM_EN, use 3-byte frames completing in S_DATA; o_Err_Cnt is tied to 0.

Structure
REQ-031 SHALL place state encodings (3-bit) and the default SYNC_BYTE/TIMEOUT_CLKS constants in shared package uart_pkg.
REQ-032 SHALL keep the saturating counters in one instantiated sub-module, uart_sat_cnt (8-bit, increment-enable, async reset); no other sub-modules.

Verification
REQ-033 SHALL cover: A5 12 34 (CSUM EB with EN) and i_Pkt_Ready=1 -> one cycle o_Pkt_Valid=1, addr 12, data 34.
REQ-034 SHALL cover: with EN, A5 12 34 00 -> no o_Pkt_Valid, o_Err_Cnt=1.
REQ-035 SHALL cover: two good frames with i_Pkt_Ready=0 -> the first frame is held, o_Drop_Cnt=1; frame 3 completes on the handshake cycle -> frame 3 is loaded.
REQ-036 SHALL cover: A5 12 then TIMEOUT_CLKS idle clocks -> o_Timeout pulses once, state S_IDLE; next A5 starts a new frame.
REQ-037 SHALL cover: 300 bad frames -> o_Err_Cnt=255; i_Rst_n low mid-frame -> all outputs 0 on the same edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet receiver: state encodings, default
// frame constants and the frame checksum helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3
  } state_e;

  localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
  localparam int         DEF_TIMEOUT_CLKS = 1740;

  // 8-bit wrapping sum of the three leading frame bytes
  function automatic logic [7:0] frame_sum(input logic [7:0] sync_b,
                                           input logic [7:0] addr_b,
                                           input logic [7:0] data_b);
    return sync_b + addr_b + data_b;
  endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// 8-bit saturating event counter with increment enable and async active-low reset.
module uart_sat_cnt (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Inc_En,
  output logic [7:0] o_Count
);

  // Count enabled events, sticking at 255
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Count <= 8'd0;
    end else if (i_Inc_En && (o_Count != 8'hFF)) begin
      o_Count <= o_Count + 8'd1;
    end else begin
      o_Count <= o_Count;
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Decodes SYNC/ADDR/DATA[/CSUM] byte frames into a one-deep write-request slot.
// UART_PKT_CHECKSUM_EN adds the checksum byte, its check and the error counter.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Pkt_Valid,
  input  logic       i_Pkt_Ready,
  output logic [7:0] o_Pkt_Addr,
  output logic [7:0] o_Pkt_Data,
  output logic       o_Timeout,
  output logic [7:0] o_Err_Cnt,
  output logic [7:0] o_Drop_Cnt
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_e      state_r;
  logic [15:0] idle_cnt_r;
  logic [7:0]  frm_addr_r;
  logic        frame_done_s;
  logic        csum_ok_s;
  logic [7:0]  pay_data_s;
  logic        load_s;
  logic        drop_inc_s;
  logic        timeout_s;
`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]  frm_data_r;
  logic        err_inc_s;
`endif

  // Detect the final byte of a frame and judge its checksum
  always_comb begin
    frame_done_s = 1'b0;
    csum_ok_s    = 1'b1;
    pay_data_s   = i_Rx_Byte;
    case (state_r)
`ifdef UART_PKT_CHECKSUM_EN
      S_CSUM: begin
        frame_done_s = i_Rx_DV;
        csum_ok_s    = (i_Rx_Byte == frame_sum(SYNC_BYTE, frm_addr_r, frm_data_r));
        pay_data_s   = frm_data_r;
      end
`else
      S_DATA: begin
        frame_done_s = i_Rx_DV;
      end
`endif
      default: begin
        frame_done_s = 1'b0;
      end
    endcase
  end

  // A good frame lands in the slot if it is empty or being freed this cycle
  assign load_s     = frame_done_s && csum_ok_s && (!o_Pkt_Valid || i_Pkt_Ready);
  assign drop_inc_s = frame_done_s && csum_ok_s && o_Pkt_Valid && !i_Pkt_Ready;
  assign timeout_s  = (state_r != S_IDLE) && !i_Rx_DV && (idle_cnt_r == TO_LAST);

  // Frame FSM, inter-byte timer and the held request slot
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r     <= S_IDLE;
      idle_cnt_r  <= 16'd0;
      frm_addr_r  <= 8'd0;
`ifdef UART_PKT_CHECKSUM_EN
      frm_data_r  <= 8'd0;
`endif
      o_Pkt_Valid <= 1'b0;
      o_Pkt_Addr  <= 8'd0;
      o_Pkt_Data  <= 8'd0;
      o_Timeout   <= 1'b0;
    end else begin
      o_Timeout <= 1'b0;

      if (load_s) begin
        o_Pkt_Valid <= 1'b1;
        o_Pkt_Addr  <= frm_addr_r;
        o_Pkt_Data  <= pay_data_s;
      end else if (o_Pkt_Valid && i_Pkt_Ready) begin
        o_Pkt_Valid <= 1'b0;
      end else begin
        o_Pkt_Valid <= o_Pkt_Valid;
      end

      if (state_r == S_IDLE) begin
        idle_cnt_r <= 16'd0;
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_r <= S_ADDR;
        end else begin
          state_r <= S_IDLE;
        end
      end else if (i_Rx_DV) begin
        // Mid-frame sync values are plain payload; no resync
        idle_cnt_r <= 16'd0;
        case (state_r)
          S_ADDR: begin
            frm_addr_r <= i_Rx_Byte;
            state_r    <= S_DATA;
          end
          S_DATA: begin
`ifdef UART_PKT_CHECKSUM_EN
            frm_data_r <= i_Rx_Byte;
            state_r    <= S_CSUM;
`else
            state_r    <= S_IDLE;
`endif
          end
          default: begin
            state_r <= S_IDLE;
          end
        endcase
      end else if (timeout_s) begin
        state_r    <= S_IDLE;
        idle_cnt_r <= 16'd0;
        o_Timeout  <= 1'b1;
      end else begin
        idle_cnt_r <= idle_cnt_r + 16'd1;
      end
    end
  end

  uart_sat_cnt u_drop_cnt (
    .i_Clock  (i_Clock),
    .i_Rst_n  (i_Rst_n),
    .i_Inc_En (drop_inc_s),
    .o_Count  (o_Drop_Cnt)
  );

`ifdef UART_PKT_CHECKSUM_EN
  assign err_inc_s = frame_done_s && !csum_ok_s;

  uart_sat_cnt u_err_cnt (
    .i_Clock  (i_Clock),
    .i_Rst_n  (i_Rst_n),
    .i_Inc_En (err_inc_s),
    .o_Count  (o_Err_Cnt)
  );
`else
  assign o_Err_Cnt = 8'd0;
`endif

endmodule
